// File: rtl/fifo_wptr_full.sv
// Write-side pointer/full controller of the async FIFO: wen is combinational, all status registered (1 clk).
// A write is dropped while wfull is set and then raises sticky overflow. Optional almost_full port under ALMOST_FULL_EN.
module fifo_wptr_full #(
    parameter int ADDR_SIZE = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic                 clr_ovf,
    output logic                 wen,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic [ADDR_SIZE:0]   wlevel,
`ifdef ALMOST_FULL_EN
    output logic                 almost_full,
`endif
    output logic                 overflow
);

    if (ADDR_SIZE < 2 || AF_THRESH < 1 || AF_THRESH > (1 << ADDR_SIZE)) begin : g_param_chk
        $error("fifo_wptr_full: illegal ADDR_SIZE or AF_THRESH");
    end

    logic [ADDR_SIZE:0] wbin_q, wbin_d;
    logic [ADDR_SIZE:0] wptr_q, wptr_d;
    logic [ADDR_SIZE:0] wlevel_q, wlevel_d;
    logic [ADDR_SIZE:0] rbin_s;
    logic               wfull_q, wfull_d;
    logic               ovf_q, ovf_d;

    assign wen = winc & ~wfull_q;

    always_comb begin
        rbin_s = '0;
        rbin_s[ADDR_SIZE] = wq2_rptr[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
        end
    end

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    always_comb begin
        wbin_d   = wbin_q + {{ADDR_SIZE{1'b0}}, wen};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wfull_d  = (wptr_d == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]});
        wlevel_d = wbin_d - rbin_s;
        ovf_d    = (winc & wfull_q) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wlevel_q <= wlevel_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef ALMOST_FULL_EN
    localparam logic [ADDR_SIZE:0] AF_LVL = AF_THRESH[ADDR_SIZE:0];
    logic af_q, af_d;

    assign af_d = (wlevel_d >= AF_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) af_q <= 1'b0;
        else        af_q <= af_d;
    end

    assign almost_full = af_q;
`endif

    assign waddr    = wbin_q[ADDR_SIZE-1:0];
    assign wptr     = wptr_q;
    assign wfull    = wfull_q;
    assign wlevel   = wlevel_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_SIZE=4): vector table plus reset/wrap/almost-full sequences.
module tb_fifo_wptr_full;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       clr_ovf;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic [4:0] wlevel;
    logic       overflow;
`ifdef ALMOST_FULL_EN
    logic       almost_full;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wptr_full #(.ADDR_SIZE(4), .AF_THRESH(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .clr_ovf  (clr_ovf),
        .wen      (wen),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wlevel   (wlevel),
`ifdef ALMOST_FULL_EN
        .almost_full (almost_full),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       winc;
        logic [4:0] rptr;
        logic       clr;
        logic       e_wen;
        logic [3:0] e_waddr;
        logic [4:0] e_wptr;
        logic       e_full;
        logic [4:0] e_lvl;
        logic       e_ovf;
    } vec_t;

    vec_t vt[$];

    function automatic logic [4:0] gray(input int k);
        logic [4:0] b;
        b = k[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic w, input logic [4:0] r, input logic c, input logic ew,
                       input int ea, input logic [4:0] ep, input logic ef, input int el,
                       input logic eo);
        vec_t v;
        v.winc = w; v.rptr = r; v.clr = c; v.e_wen = ew;
        v.e_waddr = ea[3:0]; v.e_wptr = ep; v.e_full = ef; v.e_lvl = el[4:0]; v.e_ovf = eo;
        vt.push_back(v);
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; clr_ovf = 1'b0;

        // Fill from empty, overflow attempts, clear, read-pointer advance, refill.
        for (int k = 1; k <= 16; k++) add(1, 0, 0, 1, k % 16, gray(k), k == 16, k, 0);
        for (int k = 0; k < 3; k++)   add(1, 0, 0, 0, 0, 5'b11000, 1, 16, 1);
        add(0, 0, 1, 0, 0, 5'b11000, 1, 16, 0);
        add(1, 0, 1, 0, 0, 5'b11000, 1, 16, 1);
        add(0, 0, 0, 0, 0, 5'b11000, 1, 16, 1);
        add(0, 5'b00001, 0, 0, 0, 5'b11000, 0, 15, 1);
        add(1, 5'b00001, 0, 1, 1, 5'b11001, 1, 16, 1);

        #2;
        check("rst_wptr",   wptr,     5'd0);
        check("rst_wfull",  wfull,    1'b0);
        check("rst_wlevel", wlevel,   5'd0);
        check("rst_ovf",    overflow, 1'b0);
        check("rst_waddr",  waddr,    4'd0);
        step();
        rst_n = 1'b1;

        foreach (vt[i]) begin
            winc = vt[i].winc; wq2_rptr = vt[i].rptr; clr_ovf = vt[i].clr;
            #1;
            check($sformatf("v%0d_wen", i), wen, vt[i].e_wen);
            step();
            check($sformatf("v%0d_waddr", i), waddr,    vt[i].e_waddr);
            check($sformatf("v%0d_wptr", i),  wptr,     vt[i].e_wptr);
            check($sformatf("v%0d_wfull", i), wfull,    vt[i].e_full);
            check($sformatf("v%0d_wlevel", i), wlevel,  vt[i].e_lvl);
            check($sformatf("v%0d_ovf", i),   overflow, vt[i].e_ovf);
        end
        clr_ovf = 1'b0;

        // Asynchronous reset between edges while full with overflow set.
        winc = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("arst_wptr",   wptr,     5'd0);
        check("arst_wfull",  wfull,    1'b0);
        check("arst_wlevel", wlevel,   5'd0);
        check("arst_ovf",    overflow, 1'b0);
        wq2_rptr = '0;
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_wen",   wen,   1'b1);
        check("post_rst_waddr", waddr, 4'd0);
        step();
        check("post_rst_waddr1", waddr, 4'd1);
        check("post_rst_wptr1",  wptr,  5'd1);
        check("post_rst_lvl1",   wlevel, 5'd1);

        // Wrap: keep the read pointer three behind the current write pointer.
        step();
        step();
        cnt = 3;
        check("wrap_pre_lvl", wlevel, 5'd3);
        for (int i = 0; i < 40; i++) begin
            wq2_rptr = gray(cnt - 3);
            step();
            cnt++;
            check($sformatf("wrap%0d_wptr", i), wptr, gray(cnt));
            check($sformatf("wrap%0d_full_lvl", i), {wfull, wlevel}, {1'b0, 5'd4});
        end
        check("wrap_msb", wptr[4], 1'b0);
        winc = 1'b0;

`ifdef ALMOST_FULL_EN
        rst_n = 1'b0;
        wq2_rptr = '0;
        #1;
        check("af_rst", almost_full, 1'b0);
        step();
        rst_n = 1'b1;
        winc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("af_w%0d", k), almost_full, k >= 12);
        end
        winc = 1'b0;
        wq2_rptr = gray(1);
        step();
        check("af_release", almost_full, 1'b0);
        check("af_release_lvl", wlevel, 5'd11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
